avalon_pattern_master: RTL
==========================

AVALON_PATTERN_MASTER -- requirements
Module: avalon_pattern_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, writedata/readdata width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter NUM_WORDS, default 16, words per run (at least 1).
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of word 0.
REQ-005 SHALL have parameter SEED, default 0, data value of word 0.
REQ-006 SHALL have parameter MODE, default 0: 0=tie-off (grounded master), 1=write-fill, 2=write then read-back check.
REQ-007 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, run request, sampled in IDLE only.
REQ-010 SHALL have port busy, output, 1, high in WRITE or READ.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at end of run.
REQ-012 SHALL have port error, output, 1, sticky mismatch flag.
REQ-013 SHALL have port err_count, output, 16, read-back mismatch count.
REQ-014 SHALL have ports address (output, ADDR_W), write (output, 1), writedata (output, DATA_W), read (output, 1), byte addressed.
REQ-015 SHALL have ports readdata (input, DATA_W) and waitrequest (input, 1), fixed zero-latency reads.

Function
REQ-016 MODE=0 SHALL hold all outputs at 0 permanently and ignore start, so fabric arbitration synthesizes away.
REQ-017 FSM states SHALL be IDLE, WRITE, READ, DONE.
REQ-018 IDLE with start=1 SHALL enter WRITE next cycle with address=BASE_ADDR, writedata=SEED, write=1; error and err_count cleared on the same edge.
REQ-019 While write or read is high and waitrequest=1, address, writedata, write and read SHALL hold stable.
REQ-020 A word SHALL be accepted on an edge where (write or read)=1 and waitrequest=0; the index then increments and address advances by DATA_W/8.
REQ-021 Word k SHALL use address BASE_ADDR + k*(DATA_W/8) mod 2^ADDR_W and data SEED + k mod 2^DATA_W.
REQ-022 After word NUM_WORDS-1 is accepted in WRITE: MODE=1 enters DONE; MODE=2 enters READ at word 0 with read=1 and write=0 on the next cycle.
REQ-023 In READ, readdata SHALL be sampled on the accepting edge; if it differs from the expected value, error SHALL set and err_count SHALL increment, saturating at 0xFFFF.
REQ-024 After word NUM_WORDS-1 is accepted in READ, the FSM SHALL enter DONE.
REQ-025 DONE SHALL assert done for exactly one cycle with write=read=0, then return to IDLE.
REQ-026 start outside IDLE SHALL be ignored; a start held high in IDLE after DONE SHALL begin a new run.
REQ-027 write and read SHALL never be high together.
REQ-028 With waitrequest=0, the write phase SHALL take exactly NUM_WORDS cycles, and done SHALL rise 1 cycle after the last accept.
REQ-029 The word counter SHALL be $clog2(NUM_WORDS+1) bits wide.

Reset
REQ-030 Asserting reset_n=0 SHALL force IDLE immediately and drive all outputs to 0, including mid-transfer.
REQ-031 After reset deassertion, no transfer SHALL begin without a new start.

Structure
REQ-032 State encodings and MODE constants SHALL reside in shared package pattern_master_pkg.
REQ-033 The block SHALL be a single module with no sub-modules.

Verification
REQ-034 MODE=0, start toggled randomly for 100 cycles -> address, writedata, write, read, busy and done stay 0.
REQ-035 MODE=1, NUM_WORDS=4, BASE_ADDR=0x100, SEED=0xA0, waitrequest=0 -> writes 0xA0..0xA3 to 0x100, 0x104, 0x108, 0x10C on consecutive cycles; done 1 cycle later.
REQ-036 MODE=1, waitrequest high for 3 cycles on word 1 -> address 0x104 and data 0xA1 held 4 cycles, no word skipped or duplicated.
REQ-037 MODE=2, memory model corrupts word 2 -> error=1 and err_count=1 at done; next start clears both.
REQ-038 SEED=0xFFFFFFFE, NUM_WORDS=3 -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap).
REQ-039 reset_n low during the word 2 write wait -> write=0 asynchronously; after release, idle until start.

Source files
------------

// File: rtl/pattern_master_pkg.sv
// Shared constants for the Avalon pattern master: FSM encodings, MODE values
// and the saturating mismatch-counter helper.
package pattern_master_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int MODE_TIEOFF = 0;
  localparam int MODE_FILL   = 1;
  localparam int MODE_CHECK  = 2;

  localparam int ERR_CNT_W = 16;

  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  function automatic err_cnt_t sat_inc(input err_cnt_t v);
    return (v == '1) ? v : v + err_cnt_t'(1);
  endfunction

endpackage

// File: rtl/avalon_pattern_master.sv
// Avalon-MM master that writes an incrementing pattern to a window of memory
// and, in MODE_CHECK, reads it back and counts mismatches.
module avalon_pattern_master
  import pattern_master_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                NUM_WORDS = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] SEED      = '0,
  parameter int                MODE      = MODE_TIEOFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              read,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest,
  output logic [1:0]        state_dbg
);

  localparam int                CNT_W    = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DATA_W / 8);
  // Tie-off (and any unknown MODE) never leaves IDLE, so the datapath folds away.
  localparam bit                RUN_EN   = (MODE == MODE_FILL) || (MODE == MODE_CHECK);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  err_cnt_t          err_count_q, err_count_d;

  logic              accept;
  logic              last_word;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    address_d   = address_q;
    data_d      = data_q;
    write_d     = write_q;
    read_d      = read_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_count_d = err_count_q;

    accept    = (write_q || read_q) && !waitrequest;
    last_word = (idx_q == LAST_IDX);

    case (state_q)
      ST_IDLE: begin
        if (start && RUN_EN) begin
          state_d     = ST_WRITE;
          idx_d       = '0;
          address_d   = BASE_ADDR;
          data_d      = SEED;
          write_d     = 1'b1;
          error_d     = 1'b0;
          err_count_d = '0;
        end
      end

      ST_WRITE: begin
        if (accept) begin
          if (last_word) begin
            write_d = 1'b0;
            if (MODE == MODE_CHECK) begin
              state_d   = ST_READ;
              idx_d     = '0;
              address_d = BASE_ADDR;
              data_d    = SEED;
              read_d    = 1'b1;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d     = idx_q + 1'b1;
            address_d = address_q + STRIDE;
            data_d    = data_q + 1'b1;
          end
        end
      end

      ST_READ: begin
        // data_q carries the expected word while reading back.
        if (accept) begin
          if (readdata != data_q) begin
            error_d     = 1'b1;
            err_count_d = sat_inc(err_count_q);
          end
          if (last_word) begin
            state_d = ST_DONE;
            read_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_q + 1'b1;
            address_d = address_q + STRIDE;
            data_d    = data_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
        read_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      address_q   <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      address_q   <= address_d;
      data_q      <= data_d;
      write_q     <= write_d;
      read_q      <= read_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  assign busy      = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign done      = done_q;
  assign error     = error_q;
  assign err_count = err_count_q;
  assign address   = address_q;
  assign write     = write_q;
  assign writedata = data_q;
  assign read      = read_q;
  assign state_dbg = state_q;

endmodule
